dram_write_merger: RTL and testbench

- Sits directly downstream of the DRAM write collector and consumes its dramw rdy/ack stream.
- Each beat is one DRAM line: address, per-word data, per-word byte-enable mask.
- Coalesces consecutive beats to the same line address into one held line, so partial writes from successive ALU batches reach DRAM as a single merged write.
- Emits merged lines on a registered rdy/ack port towards the DRAM write arbiter.

---
 rtl/dram_write_merger.sv | 134 +++++++++++++
 tb/tb_dram_write_merger.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_write_merger.sv
// DRAM write merger: coalesces consecutive same-address line beats into one
// held line (P) and forwards merged lines through a registered output (O).
module dram_write_merger #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int NW      = 32,
    parameter int TIMEOUT = 8,
    parameter int CW      = $clog2(TIMEOUT + 1)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_flush,
    output logic               o_idle,

    input  logic               dramw_rdy,
    output logic               dramw_ack,
    input  logic [AW-1:0]      dramw_addr,
    input  logic [NW*DW-1:0]   dramw_dat,
    input  logic [NW-1:0]      dramw_mask,

    output logic               dramo_rdy,
    input  logic               dramo_ack,
    output logic [AW-1:0]      dramo_addr,
    output logic [NW*DW-1:0]   dramo_dat,
    output logic [NW-1:0]      dramo_mask
);

    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_FIRE = CW'(TIMEOUT - 1);

    // Holding register P
    logic               p_valid;
    logic [AW-1:0]      p_addr;
    logic [NW*DW-1:0]   p_dat;
    logic [NW-1:0]      p_mask;
    logic [CW-1:0]      cnt;

    // Output register O
    logic               o_valid;
    logic [AW-1:0]      o_addr;
    logic [NW*DW-1:0]   o_dat;
    logic [NW-1:0]      o_mask;

    // Per-cycle decision terms
    logic               ofree;
    logic               beat_live;
    logic               beat_zero;
    logic               addr_hit;
    logic               accept;
    logic               do_merge;
    logic               do_load;
    logic               timed_out;
    logic               do_push;
    logic [NW*DW-1:0]   merge_dat;

    // Decide accept / merge / load / push for this cycle
    always_comb begin
        ofree     = !o_valid || dramo_ack;
        beat_live = dramw_rdy && !i_flush;
        beat_zero = (dramw_mask == '0);
        addr_hit  = p_valid && (dramw_addr == p_addr);
        // A differing address can only be taken when P can move into O.
        accept    = beat_live && (beat_zero || !p_valid || addr_hit || ofree);
        do_merge  = accept && !beat_zero && addr_hit;
        do_load   = accept && !beat_zero && !addr_hit;
        timed_out = (cnt >= CNT_FIRE);
        // A load over a valid P always displaces it (ofree is implied by accept).
        do_push   = p_valid && ofree && (do_load || i_flush || (timed_out && !do_merge));
    end

    // Word-wise overlay of the incoming beat onto the held line
    always_comb begin
        merge_dat = p_dat;
        for (int unsigned k = 0; k < NW; k++) begin
            if (dramw_mask[k]) begin
                merge_dat[k*DW +: DW] = dramw_dat[k*DW +: DW];
            end
        end
    end

    // Holding register P and its idle counter
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            p_valid <= 1'b0;
            p_addr  <= '0;
            p_dat   <= '0;
            p_mask  <= '0;
            cnt     <= '0;
        end else if (do_load) begin
            p_valid <= 1'b1;
            p_addr  <= dramw_addr;
            p_dat   <= dramw_dat;
            p_mask  <= dramw_mask;
            cnt     <= '0;
        end else if (do_merge) begin
            p_dat   <= merge_dat;
            p_mask  <= p_mask | dramw_mask;
            cnt     <= '0;
        end else if (do_push) begin
            p_valid <= 1'b0;
            cnt     <= '0;
        end else if (p_valid && (cnt != CNT_MAX)) begin
            cnt     <= cnt + CW'(1);
        end
    end

    // Output register O: reload from P on push, empty on downstream accept
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid <= 1'b0;
            o_addr  <= '0;
            o_dat   <= '0;
            o_mask  <= '0;
        end else if (do_push) begin
            o_valid <= 1'b1;
            o_addr  <= p_addr;
            o_dat   <= p_dat;
            o_mask  <= p_mask;
        end else if (dramo_ack) begin
            o_valid <= 1'b0;
        end
    end

    // Port drive
    always_comb begin
        dramw_ack  = accept;
        dramo_rdy  = o_valid;
        dramo_addr = o_addr;
        dramo_dat  = o_dat;
        dramo_mask = o_mask;
        o_idle     = !p_valid && !o_valid;
    end

endmodule

// File: tb/tb_dram_write_merger.sv
// Bench for dram_write_merger: directed scenarios plus random beats, with a
// line-level reference model feeding a scoreboard checked by an output monitor.
module tb_dram_write_merger;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int NW      = 8;
    localparam int TIMEOUT = 8;
    localparam int LW      = NW * DW;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [LW-1:0] dat;
        logic [NW-1:0] mask;
    } line_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            idle;
    logic            dramw_rdy;
    logic            dramw_ack;
    logic [AW-1:0]   dramw_addr;
    logic [LW-1:0]   dramw_dat;
    logic [NW-1:0]   dramw_mask;
    logic            dramo_rdy;
    logic            dramo_ack;
    logic [AW-1:0]   dramo_addr;
    logic [LW-1:0]   dramo_dat;
    logic [NW-1:0]   dramo_mask;
    logic            sink_en;

    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model: current open line and closed lines awaiting output
    line_t       exp_q[$];
    line_t       m_cur;
    bit          m_valid = 1'b0;
    int unsigned m_last = 0;

    dram_write_merger #(
        .AW(AW), .DW(DW), .NW(NW), .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .o_idle(idle),
        .dramw_rdy(dramw_rdy), .dramw_ack(dramw_ack), .dramw_addr(dramw_addr),
        .dramw_dat(dramw_dat), .dramw_mask(dramw_mask),
        .dramo_rdy(dramo_rdy), .dramo_ack(dramo_ack), .dramo_addr(dramo_addr),
        .dramo_dat(dramo_dat), .dramo_mask(dramo_mask)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Sink only acknowledges a presented line
    assign dramo_ack = sink_en && dramo_rdy;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_close();
        if (m_valid) begin
            exp_q.push_back(m_cur);
            m_valid = 1'b0;
        end
    endfunction

    // A beat joins the open line if same address and it arrives no more than
    // TIMEOUT cycles after the previous accepted beat of that line.
    function automatic void model_beat(input line_t b, input int unsigned c);
        if (b.mask == '0) return;
        if (m_valid && (m_cur.addr == b.addr) && (c - m_last <= TIMEOUT)) begin
            for (int k = 0; k < NW; k++)
                if (b.mask[k]) m_cur.dat[k*DW +: DW] = b.dat[k*DW +: DW];
            m_cur.mask = m_cur.mask | b.mask;
        end else begin
            model_close();
            m_cur   = b;
            m_valid = 1'b1;
        end
        m_last = c;
    endfunction

    // Monitor: compare every accepted output line against the scoreboard
    always @(negedge clk) begin
        if (!rst && dramo_rdy && dramo_ack) begin
            line_t e;
            if (exp_q.size() == 0 && m_valid && (cyc - m_last) >= TIMEOUT + 1)
                model_close();
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected: got addr %0h mask %0h, no line expected",
                         dramo_addr, dramo_mask);
            end else begin
                e = exp_q.pop_front();
                chk("out_addr", LW'(dramo_addr), LW'(e.addr));
                chk("out_mask", LW'(dramo_mask), LW'(e.mask));
                chk("out_dat", dramo_dat, e.dat);
            end
            chk("out_mask_nonzero", LW'(dramo_mask != '0), LW'(1));
        end
        if (!rst && !dramw_rdy && dramw_ack)
            chk("ack_without_rdy", LW'(dramw_ack), LW'(0));
    end

    function automatic line_t mk(input logic [AW-1:0] a, input logic [NW-1:0] m, input logic [LW-1:0] d);
        line_t b;
        b.addr = a;
        b.mask = m;
        b.dat  = d;
        return b;
    endfunction

    task automatic present(input line_t b);
        dramw_addr = b.addr;
        dramw_dat  = b.dat;
        dramw_mask = b.mask;
        dramw_rdy  = 1'b1;
    endtask

    task automatic wait_accept(input line_t b, output int unsigned acc);
        bit got = 1'b0;
        acc = cyc;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (dramw_ack) begin
                got = 1'b1;
                acc = cyc;
                model_beat(b, cyc);
            end
            @(posedge clk); #1;
        end
        dramw_rdy = 1'b0;
        chk("beat_accepted", LW'(got), LW'(1));
    endtask

    task automatic send(input line_t b, output int unsigned acc);
        present(b);
        wait_accept(b, acc);
    endtask

    // Leaves the caller at the negedge where dramo_rdy first rose
    task automatic expect_latency(input string name, input int unsigned t);
        bit seen = 1'b0;
        for (int i = 0; i < 4 * TIMEOUT && !seen; i++) begin
            @(negedge clk);
            if (dramo_rdy) seen = 1'b1;
        end
        chk(name, LW'(seen ? cyc - t : 0), LW'(TIMEOUT + 1));
    endtask

    task automatic drain(input string name);
        repeat (2 * TIMEOUT + 4) @(posedge clk);
        #1;
        chk({name, "_idle"}, LW'(idle), LW'(1));
        chk({name, "_queue_empty"}, LW'(exp_q.size()), LW'(0));
        chk({name, "_model_closed"}, LW'(m_valid), LW'(0));
    endtask

    initial begin
        line_t       b;
        int unsigned t;
        logic [LW-1:0] d;

        rst = 1'b1; flush = 1'b0; sink_en = 1'b1;
        dramw_rdy = 1'b0; dramw_addr = '0; dramw_dat = '0; dramw_mask = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_dramo_rdy", LW'(dramo_rdy), LW'(0));
        chk("rst_dramw_ack", LW'(dramw_ack), LW'(0));
        chk("rst_idle", LW'(idle), LW'(1));
        chk("rst_dramo_addr", LW'(dramo_addr), LW'(0));
        chk("rst_dramo_mask", LW'(dramo_mask), LW'(0));
        chk("rst_dramo_dat", dramo_dat, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Same-address merge of disjoint words
        d = '0; d[0 +: DW] = 32'hAA;
        send(mk(32'h100, 8'h01, d), t);
        d = '0; d[DW +: DW] = 32'hBB;
        send(mk(32'h100, 8'h02, d), t);
        expect_latency("merge_latency", t);
        chk("merge_mask", LW'(dramo_mask), LW'(8'h03));
        chk("merge_w0", LW'(dramo_dat[0 +: DW]), LW'(32'hAA));
        chk("merge_w1", LW'(dramo_dat[DW +: DW]), LW'(32'hBB));
        @(posedge clk); #1;
        drain("merge");

        // Overlapping merge: later word wins
        d = '0; d[0 +: DW] = 32'h11;
        send(mk(32'h180, 8'h01, d), t);
        d = '0; d[0 +: DW] = 32'h22;
        send(mk(32'h180, 8'h01, d), t);
        expect_latency("overlap_latency", t);
        chk("overlap_w0", LW'(dramo_dat[0 +: DW]), LW'(32'h22));
        chk("overlap_mask", LW'(dramo_mask), LW'(8'h01));
        @(posedge clk); #1;
        drain("overlap");

        // Address change under backpressure
        sink_en = 1'b0;
        send(mk(32'h100, 8'h05, {8{32'h1111_0000}}), t);
        send(mk(32'h200, 8'h03, {8{32'h2222_0000}}), t);
        b = mk(32'h300, 8'h09, {8{32'h3333_0000}});
        present(b);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_ack_low", LW'(dramw_ack), LW'(0));
            chk("stall_out_held", LW'(dramo_rdy), LW'(1));
            @(posedge clk); #1;
        end
        sink_en = 1'b1;
        wait_accept(b, t);
        drain("stall");

        // Zero-mask drop
        send(mk(32'h350, 8'h00, {8{32'hDEAD_BEEF}}), t);
        repeat (TIMEOUT + 3) @(posedge clk);
        #1;
        chk("zero_no_output", LW'(dramo_rdy), LW'(0));
        chk("zero_idle", LW'(idle), LW'(1));

        // Flush
        send(mk(32'h400, 8'h0F, {8{32'h4444_4444}}), t);
        flush = 1'b1;
        b = mk(32'h500, 8'h01, {8{32'h5555_5555}});
        present(b);
        @(negedge clk);
        chk("flush_ack_low0", LW'(dramw_ack), LW'(0));
        model_close();
        @(posedge clk); #1;
        @(negedge clk);
        chk("flush_out_latency", LW'(dramo_rdy ? cyc - t : 0), LW'(2));
        chk("flush_ack_low1", LW'(dramw_ack), LW'(0));
        @(posedge clk); #1;
        @(negedge clk);
        chk("flush_idle", LW'(idle), LW'(1));
        chk("flush_ack_low2", LW'(dramw_ack), LW'(0));
        @(posedge clk); #1;
        flush = 1'b0;
        wait_accept(b, t);
        drain("flush");

        // Back-to-back alternating addresses
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < NW; k++) d[k*DW +: DW] = $urandom();
            b = mk((i % 2) ? 32'h20 : 32'h10, NW'($urandom()) | 8'h01, d);
            present(b);
            @(negedge clk);
            chk("b2b_ack", LW'(dramw_ack), LW'(1));
            if (dramw_ack) model_beat(b, cyc);
            if (i >= 2) chk("b2b_out_valid", LW'(dramo_rdy), LW'(1));
            @(posedge clk); #1;
        end
        dramw_rdy = 1'b0;
        drain("b2b");

        // Reset mid-stream with P and O both occupied
        sink_en = 1'b0;
        send(mk(32'h700, 8'h11, {8{32'h7777_7777}}), t);
        send(mk(32'h800, 8'h22, {8{32'h8888_8888}}), t);
        @(negedge clk);
        chk("pre_rst_out_valid", LW'(dramo_rdy), LW'(1));
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_dramo_rdy", LW'(dramo_rdy), LW'(0));
        chk("mid_rst_idle", LW'(idle), LW'(1));
        exp_q.delete();
        m_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        sink_en = 1'b1;
        @(posedge clk); #1;
        send(mk(32'h900, 8'h30, {8{32'h9999_0000}}), t);
        expect_latency("post_rst_latency", t);
        chk("post_rst_mask", LW'(dramo_mask), LW'(8'h30));
        @(posedge clk); #1;
        drain("post_rst");

        // Random beats with gaps straddling the merge window
        for (int i = 0; i < 80; i++) begin
            int unsigned gap;
            logic [NW-1:0] m;
            gap = $urandom_range(1, TIMEOUT + 2);
            repeat (gap - 1) @(posedge clk);
            #1;
            for (int k = 0; k < NW; k++) d[k*DW +: DW] = $urandom();
            m = NW'($urandom() & $urandom());
            if ($urandom_range(0, 7) == 0) m = '0;
            send(mk(32'h1000 + 32'($urandom_range(0, 1)), m, d), t);
        end
        drain("random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
